// File: rtl/msdft_corr_sequencer.sv
// Run-time sequencer ahead of the dual-MSDFT correlator: zero-flushes both delay lines,
// drains the datapath, gates accumulator valid and applies config only at frame boundaries.
module msdft_corr_sequencer #(
    parameter int unsigned DIN_WIDTH     = 14,
    parameter int unsigned DFT_LEN       = 1024,
    parameter int unsigned SETTLE_CYCLES = 12,
    parameter int unsigned ACC_LEN_RST   = 1024,
    parameter int unsigned DELAY_RST     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 cfg_delay_line,
    input  logic [31:0]                 cfg_acc_len,
    input  logic                        cfg_update,
    output logic                        cfg_busy,
    input  logic signed [DIN_WIDTH-1:0] din1_re,
    input  logic signed [DIN_WIDTH-1:0] din1_im,
    input  logic signed [DIN_WIDTH-1:0] din2_re,
    input  logic signed [DIN_WIDTH-1:0] din2_im,
    input  logic                        din_valid,
    output logic signed [DIN_WIDTH-1:0] dout1_re,
    output logic signed [DIN_WIDTH-1:0] dout1_im,
    output logic signed [DIN_WIDTH-1:0] dout2_re,
    output logic signed [DIN_WIDTH-1:0] dout2_im,
    output logic                        dout_valid,
    output logic [31:0]                 delay_line,
    output logic [31:0]                 acc_len,
    input  logic                        pipe_valid,
    output logic                        acc_valid,
    output logic                        acc_done,
    output logic                        acc_dump_valid,
    output logic [1:0]                  state,
    output logic [15:0]                 dropped_count
);

    localparam int unsigned CFG_W   = 32;
    localparam int unsigned DROP_W  = 16;
    localparam int unsigned CNT_MAX = (DFT_LEN > SETTLE_CYCLES) ? DFT_LEN : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  FLUSH_LAST  = CNT_W'(DFT_LEN - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_MAX    = '1;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t             state_q, state_next;
    logic [CNT_W-1:0]   cnt_q, cnt_next;
    logic [CFG_W-1:0]   frame_cnt;
    logic [CFG_W-1:0]   pend_delay, pend_len;
    logic [CFG_W-1:0]   new_delay, new_len;
    logic               run_entry, frame_end, apply_cfg;

    function automatic logic [CFG_W-1:0] clamp_len(input logic [CFG_W-1:0] len);
        return (len == '0) ? CFG_W'(1) : len;
    endfunction

    assign acc_valid = pipe_valid & (state_q == ST_RUN);
    assign state     = state_q;

    // Next-state logic; a cfg_update coinciding with an apply point is taken directly.
    // Outside RUN, cfg_busy doubles as the restart flag.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        run_entry  = 1'b0;
        frame_end  = 1'b0;
        apply_cfg  = 1'b0;
        new_delay  = cfg_update ? cfg_delay_line : pend_delay;
        new_len    = cfg_update ? clamp_len(cfg_acc_len) : pend_len;
        case (state_q)
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_next = '0;
                    if (cfg_busy || cfg_update) begin
                        state_next = ST_FLUSH;
                        apply_cfg  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                        run_entry  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (acc_valid && (frame_cnt == acc_len)) begin
                    frame_end = 1'b1;
                    if (cfg_busy || cfg_update) begin
                        apply_cfg  = 1'b1;
                        state_next = ST_FLUSH;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = ST_FLUSH;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_line     <= CFG_W'(DELAY_RST);
            acc_len        <= CFG_W'(ACC_LEN_RST);
            pend_delay     <= '0;
            pend_len       <= '0;
            cfg_busy       <= 1'b0;
            dout1_re       <= '0;
            dout1_im       <= '0;
            dout2_re       <= '0;
            dout2_im       <= '0;
            dout_valid     <= 1'b0;
            dropped_count  <= '0;
            acc_done       <= 1'b0;
            acc_dump_valid <= 1'b0;
            frame_cnt      <= CFG_W'(1);
        end else begin
            if (apply_cfg) begin
                delay_line <= new_delay;
                acc_len    <= new_len;
                cfg_busy   <= 1'b0;
            end else if (cfg_update) begin
                pend_delay <= cfg_delay_line;
                pend_len   <= clamp_len(cfg_acc_len);
                cfg_busy   <= 1'b1;
            end

            // Zeros to the cores during flush, registered pass-through in RUN.
            dout_valid <= (state_q == ST_FLUSH) || ((state_q == ST_RUN) && din_valid);
            dout1_re   <= (state_q == ST_RUN) ? din1_re : '0;
            dout1_im   <= (state_q == ST_RUN) ? din1_im : '0;
            dout2_re   <= (state_q == ST_RUN) ? din2_re : '0;
            dout2_im   <= (state_q == ST_RUN) ? din2_im : '0;

            if ((state_q != ST_RUN) && din_valid && (dropped_count != DROP_MAX))
                dropped_count <= dropped_count + DROP_W'(1);

            acc_done       <= run_entry | frame_end;
            acc_dump_valid <= frame_end;
            if (run_entry)
                frame_cnt <= CFG_W'(1);
            else if (acc_valid)
                frame_cnt <= frame_end ? CFG_W'(1) : frame_cnt + CFG_W'(1);
        end
    end

endmodule
